// File: rtl/ram_responder.sv
// ram_responder: byte-addressed big-endian data memory answering a four-phase
// MOV/MOC handshake. A request is captured in IDLE, held for WAIT_CYCLES
// cycles, committed, then MOC is held until the requester drops MOV.
module ram_responder #(
  parameter int ADDR_WIDTH  = 9,
  parameter int WAIT_CYCLES = 2
) (
  input  logic        Clk,
  input  logic        Reset_n,
  input  logic        MOV,
  input  logic        RW,
  input  logic [1:0]  Size,
  input  logic [31:0] Address,
  input  logic [31:0] DataIn,
  output logic [31:0] DataOut,
  output logic        MOC,
  output logic        Misalign
);
  localparam int DEPTH     = 1 << ADDR_WIDTH;
  localparam int NUM_LANES = 4;
  localparam int CNT_W     = (WAIT_CYCLES > 0) ? $clog2(WAIT_CYCLES + 1) : 1;

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_DONE} state_t;

  typedef struct packed {
    logic                  rw;
    logic [1:0]            size;
    logic [ADDR_WIDTH-1:0] addr;
    logic [31:0]           data;
  } req_t;

  state_t     state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  req_t       req_q, req_d;
  logic       moc_q, moc_d;
  logic       mis_q, mis_d;
  logic [31:0] dout_q, dout_d;

  logic [7:0] mem [DEPTH];

  // Byte lanes: lane k touches mem[addr+k]; lane 0 is the most significant byte.
  logic [NUM_LANES-1:0][ADDR_WIDTH-1:0] lane_addr;
  logic [NUM_LANES-1:0][7:0]            lane_rd;
  logic [NUM_LANES-1:0][7:0]            wr_byte;
  logic [NUM_LANES-1:0]                 wr_en;
  logic [31:0]                          rd_word;
  logic                                 req_err;

  // Address bits above the storage size are deliberately discarded (aliasing).
  logic unused_addr_hi;
  assign unused_addr_hi = ^Address[31:ADDR_WIDTH];

  for (genvar k = 0; k < NUM_LANES; k++) begin : g_lane
    assign lane_addr[k] = req_q.addr + ADDR_WIDTH'(k);
    assign lane_rd[k]   = mem[lane_addr[k]];
  end

  assign req_err = (req_q.size == 2'b11) ||
                   (req_q.size == 2'b01 && req_q.addr[0]) ||
                   (req_q.size == 2'b10 && req_q.addr[1:0] != 2'b00);

  // Big-endian, zero-extended read assembly from the captured request.
  always_comb begin
    rd_word = '0;
    unique case (req_q.size)
      2'b00:   rd_word = {24'b0, lane_rd[0]};
      2'b01:   rd_word = {16'b0, lane_rd[0], lane_rd[1]};
      default: rd_word = {lane_rd[0], lane_rd[1], lane_rd[2], lane_rd[3]};
    endcase
  end

  // Handshake FSM: capture, wait countdown, commit, hold until MOV drops.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    req_d   = req_q;
    moc_d   = moc_q;
    mis_d   = mis_q;
    dout_d  = dout_q;
    wr_en   = '0;
    wr_byte = '0;
    unique case (state_q)
      S_IDLE: begin
        if (MOV) begin
          req_d.rw   = RW;
          req_d.size = Size;
          req_d.addr = Address[ADDR_WIDTH-1:0];
          req_d.data = DataIn;
          cnt_d      = CNT_W'(WAIT_CYCLES);
          state_d    = S_WAIT;
        end
      end
      S_WAIT: begin
        if (cnt_q != '0) begin
          cnt_d = cnt_q - CNT_W'(1);
        end else begin
          moc_d   = 1'b1;
          state_d = S_DONE;
          if (req_err) begin
            mis_d  = 1'b1;
            dout_d = '0;
          end else if (req_q.rw) begin
            dout_d = rd_word;
          end else begin
            unique case (req_q.size)
              2'b00: begin
                wr_en      = 4'b0001;
                wr_byte[0] = req_q.data[7:0];
              end
              2'b01: begin
                wr_en      = 4'b0011;
                wr_byte[0] = req_q.data[15:8];
                wr_byte[1] = req_q.data[7:0];
              end
              default: begin
                wr_en      = 4'b1111;
                wr_byte[0] = req_q.data[31:24];
                wr_byte[1] = req_q.data[23:16];
                wr_byte[2] = req_q.data[15:8];
                wr_byte[3] = req_q.data[7:0];
              end
            endcase
          end
        end
      end
      S_DONE: begin
        if (!MOV) begin
          moc_d   = 1'b0;
          mis_d   = 1'b0;
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Control and output registers; reset aborts any pending access.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      req_q   <= '0;
      moc_q   <= 1'b0;
      mis_q   <= 1'b0;
      dout_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      req_q   <= req_d;
      moc_q   <= moc_d;
      mis_q   <= mis_d;
      dout_q  <= dout_d;
    end
  end

  // Storage array, never reset; write lanes only fire on a committed store.
  always_ff @(posedge Clk) begin
    for (int k = 0; k < NUM_LANES; k++) begin
      if (wr_en[k]) mem[lane_addr[k]] <= wr_byte[k];
    end
  end

  assign DataOut  = dout_q;
  assign MOC      = moc_q;
  assign Misalign = mis_q;

endmodule

// File: tb/tb_ram_responder.sv
// Self-checking bench for ram_responder: directed table, handshake/reset
// sequences, then randomized traffic against a byte-array reference model.
module tb_ram_responder;
  localparam int AW    = 9;
  localparam int WC    = 2;
  localparam int LAT   = WC + 1;
  localparam int DEPTH = 1 << AW;

  logic        Clk = 1'b0;
  logic        Reset_n = 1'b0;
  logic        MOV = 1'b0;
  logic        RW = 1'b0;
  logic [1:0]  Size = 2'b00;
  logic [31:0] Address = '0;
  logic [31:0] DataIn = '0;
  logic [31:0] DataOut;
  logic        MOC;
  logic        Misalign;

  ram_responder #(.ADDR_WIDTH(AW), .WAIT_CYCLES(WC)) dut (
    .Clk(Clk), .Reset_n(Reset_n), .MOV(MOV), .RW(RW), .Size(Size),
    .Address(Address), .DataIn(DataIn), .DataOut(DataOut), .MOC(MOC),
    .Misalign(Misalign)
  );

  always #5 Clk = ~Clk;

  int n_cmp = 0;
  int n_bad = 0;
  logic [7:0]  mem_m [DEPTH];
  logic [31:0] last_dout = '0;

  typedef struct {
    logic        rw;
    logic [1:0]  sz;
    logic [31:0] addr;
    logic [31:0] din;
    logic [31:0] exp_d;
    logic        exp_m;
  } vec_t;

  vec_t tbl [18];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  // Reference: memory as a plain byte array, accesses computed from the rules.
  task automatic model_access(input logic rw, input logic [1:0] sz, input logic [31:0] addr,
                              input logic [31:0] din, output logic [31:0] ed, output logic em);
    int a, nb;
    a  = int'(addr % DEPTH);
    nb = (sz == 2'd0) ? 1 : (sz == 2'd1) ? 2 : 4;
    if (sz == 2'd3 || (a % nb) != 0) begin
      ed = '0;
      em = 1'b1;
    end else if (rw) begin
      ed = '0;
      for (int i = 0; i < nb; i++) ed = (ed << 8) | 32'(mem_m[a + i]);
      em = 1'b0;
    end else begin
      for (int i = 0; i < nb; i++) mem_m[a + i] = 8'(din >> (8 * (nb - 1 - i)));
      ed = last_dout;
      em = 1'b0;
    end
    last_dout = ed;
  endtask

  // One full four-phase transaction; lat counts edges from sampling to MOC.
  task automatic access(input logic rw, input logic [1:0] sz, input logic [31:0] a,
                        input logic [31:0] d, output logic [31:0] q, output logic m,
                        output int lat);
    int n;
    @(negedge Clk);
    MOV = 1'b1; RW = rw; Size = sz; Address = a; DataIn = d;
    @(posedge Clk);
    lat = 0;
    do begin
      @(posedge Clk); #1;
      lat++;
    end while (!MOC && lat < 20);
    q = DataOut;
    m = Misalign;
    @(negedge Clk);
    MOV = 1'b0;
    n = 0;
    while (MOC && n < 20) begin
      @(posedge Clk); #1;
      n++;
    end
    chk("moc_release", 32'(MOC), 32'd0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] q, ed, a, d;
    logic        m, em, rw, prev;
    logic [1:0]  sz;
    int          lat, cnt, first;

    tbl[0]  = '{1'b0, 2'd2, 32'h010, 32'hDEADBEEF, 32'h0000_0000, 1'b0};
    tbl[1]  = '{1'b1, 2'd2, 32'h010, 32'h0,        32'hDEAD_BEEF, 1'b0};
    tbl[2]  = '{1'b1, 2'd0, 32'h010, 32'h0,        32'h0000_00DE, 1'b0};
    tbl[3]  = '{1'b1, 2'd0, 32'h013, 32'h0,        32'h0000_00EF, 1'b0};
    tbl[4]  = '{1'b1, 2'd1, 32'h012, 32'h0,        32'h0000_BEEF, 1'b0};
    tbl[5]  = '{1'b0, 2'd2, 32'h020, 32'h0,        32'h0000_BEEF, 1'b0};
    tbl[6]  = '{1'b0, 2'd1, 32'h022, 32'hABCD1234, 32'h0000_BEEF, 1'b0};
    tbl[7]  = '{1'b1, 2'd2, 32'h020, 32'h0,        32'h0000_1234, 1'b0};
    tbl[8]  = '{1'b0, 2'd2, 32'h000, 32'h55667788, 32'h0000_1234, 1'b0};
    tbl[9]  = '{1'b0, 2'd2, 32'h002, 32'h11111111, 32'h0000_0000, 1'b1};
    tbl[10] = '{1'b1, 2'd2, 32'h000, 32'h0,        32'h5566_7788, 1'b0};
    tbl[11] = '{1'b1, 2'd3, 32'h000, 32'h0,        32'h0000_0000, 1'b1};
    tbl[12] = '{1'b0, 2'd3, 32'h000, 32'hFFFFFFFF, 32'h0000_0000, 1'b1};
    tbl[13] = '{1'b1, 2'd1, 32'h001, 32'h0,        32'h0000_0000, 1'b1};
    tbl[14] = '{1'b1, 2'd2, 32'h000, 32'h0,        32'h5566_7788, 1'b0};
    tbl[15] = '{1'b0, 2'd0, 32'h200, 32'h000000A5, 32'h5566_7788, 1'b0};
    tbl[16] = '{1'b1, 2'd0, 32'h000, 32'h0,        32'h0000_00A5, 1'b0};
    tbl[17] = '{1'b1, 2'd2, 32'h000, 32'h0,        32'hA566_7788, 1'b0};

    // Reset state
    repeat (3) @(posedge Clk);
    #1;
    chk("reset_moc", 32'(MOC), 32'd0);
    chk("reset_mis", 32'(Misalign), 32'd0);
    chk("reset_dout", DataOut, 32'd0);
    @(negedge Clk);
    Reset_n = 1'b1;

    // Directed table
    foreach (tbl[i]) begin
      access(tbl[i].rw, tbl[i].sz, tbl[i].addr, tbl[i].din, q, m, lat);
      model_access(tbl[i].rw, tbl[i].sz, tbl[i].addr, tbl[i].din, ed, em);
      chk($sformatf("tbl%0d_dout", i), q, tbl[i].exp_d);
      chk($sformatf("tbl%0d_mis", i), 32'(m), 32'(tbl[i].exp_m));
      chk($sformatf("tbl%0d_lat", i), 32'(lat), 32'(LAT));
    end

    // MOV pulsed for one cycle: MOC high exactly one cycle, at edge LAT
    @(negedge Clk);
    MOV = 1'b1; RW = 1'b1; Size = 2'd2; Address = 32'h010;
    @(posedge Clk);
    @(negedge Clk);
    MOV = 1'b0;
    cnt = 0; first = -1; q = '0;
    for (int i = 1; i <= 8; i++) begin
      @(posedge Clk); #1;
      if (MOC) begin
        cnt++;
        if (first < 0) begin first = i; q = DataOut; end
      end
    end
    model_access(1'b1, 2'd2, 32'h010, 32'h0, ed, em);
    chk("pulse_moc_cycles", 32'(cnt), 32'd1);
    chk("pulse_moc_edge", 32'(first), 32'(LAT));
    chk("pulse_dout", q, ed);

    // MOV held high: one access, MOC rises once and stays
    @(negedge Clk);
    MOV = 1'b1; RW = 1'b1; Size = 2'd0; Address = 32'h013;
    @(posedge Clk);
    cnt = 0; prev = 1'b0;
    for (int i = 0; i < 12; i++) begin
      @(posedge Clk); #1;
      if (MOC && !prev) cnt++;
      prev = MOC;
    end
    model_access(1'b1, 2'd0, 32'h013, 32'h0, ed, em);
    chk("held_moc_rises", 32'(cnt), 32'd1);
    chk("held_moc_level", 32'(MOC), 32'd1);
    chk("held_dout", DataOut, ed);
    @(negedge Clk);
    MOV = 1'b0;
    @(posedge Clk); #1;
    chk("held_moc_drop", 32'(MOC), 32'd0);

    // Reset during WAIT aborts the write
    access(1'b0, 2'd2, 32'h030, 32'hCAFE0001, q, m, lat);
    model_access(1'b0, 2'd2, 32'h030, 32'hCAFE0001, ed, em);
    @(negedge Clk);
    MOV = 1'b1; RW = 1'b0; Size = 2'd2; Address = 32'h030; DataIn = 32'h12345678;
    @(posedge Clk);
    @(posedge Clk);
    #2;
    Reset_n = 1'b0;
    #1;
    chk("rst_wait_moc", 32'(MOC), 32'd0);
    chk("rst_wait_dout", DataOut, 32'd0);
    @(negedge Clk);
    MOV = 1'b0;
    @(negedge Clk);
    Reset_n = 1'b1;
    last_dout = '0;
    access(1'b1, 2'd2, 32'h030, 32'h0, q, m, lat);
    model_access(1'b1, 2'd2, 32'h030, 32'h0, ed, em);
    chk("rst_wait_keep", q, 32'hCAFE0001);

    // Reset during DONE: committed write stands, outputs clear
    @(negedge Clk);
    MOV = 1'b1; RW = 1'b0; Size = 2'd2; Address = 32'h034; DataIn = 32'h01020304;
    cnt = 0;
    do begin @(posedge Clk); #1; cnt++; end while (!MOC && cnt < 20);
    chk("rst_done_moc_seen", 32'(MOC), 32'd1);
    Reset_n = 1'b0;
    #1;
    chk("rst_done_moc", 32'(MOC), 32'd0);
    chk("rst_done_dout", DataOut, 32'd0);
    @(negedge Clk);
    MOV = 1'b0;
    @(negedge Clk);
    Reset_n = 1'b1;
    model_access(1'b0, 2'd2, 32'h034, 32'h01020304, ed, em);
    last_dout = '0;
    access(1'b1, 2'd2, 32'h034, 32'h0, q, m, lat);
    model_access(1'b1, 2'd2, 32'h034, 32'h0, ed, em);
    chk("rst_done_keep", q, 32'h01020304);

    // Prefill every word so random reads see defined contents
    for (int w = 0; w < DEPTH; w += 4) begin
      d = $urandom;
      access(1'b0, 2'd2, 32'(w), d, q, m, lat);
      model_access(1'b0, 2'd2, 32'(w), d, ed, em);
      chk($sformatf("fill%0d_mis", w), 32'(m), 32'(em));
    end

    // Randomized traffic, full 32-bit addresses to exercise aliasing
    for (int i = 0; i < 200; i++) begin
      rw = 1'($urandom_range(0, 1));
      sz = 2'($urandom_range(0, 3));
      a  = $urandom;
      if ($urandom_range(0, 3) != 0) a[1:0] = 2'b00;
      d  = $urandom;
      access(rw, sz, a, d, q, m, lat);
      model_access(rw, sz, a, d, ed, em);
      chk($sformatf("rnd%0d_dout", i), q, ed);
      chk($sformatf("rnd%0d_mis", i), 32'(m), 32'(em));
      chk($sformatf("rnd%0d_lat", i), 32'(lat), 32'(LAT));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/ram_responder.md
# ram_responder

Byte-addressed data memory that answers load/store requests issued by the processor's memory interface: the MAR-driven address, the MDR-driven write data and the MDR-bound read data. It is the memory end of that protocol. It captures a request on MOV, waits a programmable number of cycles, then performs the access and raises MOC. MOC is held until the requester drops MOV, forming a four-phase handshake. Supported accesses are big-endian byte, halfword and word, with misalignment detection.

## Interface
- ADDR_WIDTH, 9: storage is 2^ADDR_WIDTH bytes; only the low ADDR_WIDTH address bits are used.
- WAIT_CYCLES, 2: extra wait cycles before each access commits (0 allowed).
- Clk  input  1  system clock, rising-edge.
- Reset_n  input  1  asynchronous, active-low reset.
- MOV  input  1  memory operation valid (request).
- RW  input  1  1 = read, 0 = write.
- Size  input  2  00 byte, 01 halfword, 10 word, 11 reserved.
- Address  input  32  byte address (from MAR).
- DataIn  input  32  write data (from MDR).
- DataOut  output  32  read data (to MDR input).
- MOC  output  1  memory operation complete.
- Misalign  output  1  request rejected (misaligned or reserved Size); valid while MOC=1.

## Operation
- FSM states IDLE, WAIT, DONE.
- IDLE:
  - On an edge with MOV=1, capture Address[ADDR_WIDTH-1:0], RW, Size and DataIn.
  - Load cnt=WAIT_CYCLES and go to WAIT.
  - Inputs are ignored outside IDLE.
- WAIT:
  - If cnt≠0, decrement cnt.
  - If cnt=0, commit the access, set MOC=1 and go to DONE.
- DONE:
  - Hold MOC, DataOut and Misalign.
  - On an edge with MOV=0, clear MOC and Misalign and go to IDLE.
  - DataOut keeps its last value.
- MOV dropped during WAIT: the captured request still commits. MOC is then high for exactly one cycle, because DONE exits on the next edge.
- Error check: halfword with a[0]=1, word with a[1:0]≠00, or Size=11 is an error.
  - No memory write.
  - DataOut=0, Misalign=1, MOC=1.
- Read (big-endian, zero-extended):
  - Byte: DataOut={24'b0, mem[a]}.
  - Halfword: {16'b0, mem[a], mem[a+1]}.
  - Word: {mem[a], mem[a+1], mem[a+2], mem[a+3]}.
- Write (DataOut unchanged):
  - Byte: mem[a]=DataIn[7:0].
  - Halfword: mem[a]=DataIn[15:8], mem[a+1]=DataIn[7:0].
  - Word: mem[a..a+3]=DataIn[31:24], [23:16], [15:8], [7:0].
- Address wrap: bits above ADDR_WIDTH are discarded, so 2^ADDR_WIDTH+x aliases x.

## Timing
- Reset (asynchronous, immediate):
  - State=IDLE, cnt=0, MOC=0, Misalign=0, DataOut=0.
  - Memory contents are not reset (undefined until written).
- Latency: MOV sampled at edge k; the access commits and MOC rises at edge k+WAIT_CYCLES+1.
  - WAIT_CYCLES=2: MOC rises 3 edges after the sampling edge.
  - WAIT_CYCLES=0: MOC rises 1 edge after the sampling edge.
- Write data is readable by any request sampled after MOC rises.
- MOC falls at the first edge in DONE where MOV=0.
  - The earliest next request is sampled one edge after that (IDLE must see MOV=1).
- Reset asserted in WAIT: the access is aborted and memory is untouched.
- Reset asserted in DONE: the committed access stands; outputs clear.
- MOV held high continuously: exactly one access is performed. A new request requires MOV low, then high again.

## Test plan
- Word write then read, W=2:
  - Write 0xDEADBEEF to 0x010; MOC rises exactly 3 edges after the sampling edge.
  - Word read of 0x010 returns DataOut=0xDEADBEEF, Misalign=0.
- Big-endian sub-word reads after the 0x010 word write:
  - Byte reads: 0x010 → 0x000000DE, 0x013 → 0x000000EF.
  - Halfword read: 0x012 → 0x0000BEEF.
- Halfword write:
  - Word-write 0 to 0x020, then halfword-write 0x????1234 to 0x022.
  - Word read of 0x020 returns 0x00001234.
- Misalignment:
  - Word write 0x11111111 to 0x002 → MOC=1, Misalign=1, DataOut=0.
  - Subsequent word read of 0x000 shows the prior contents, unchanged.
  - Size=11 at 0x000 gives the same result.
- Handshake and reset:
  - MOV pulsed for one cycle: MOC is high for exactly one cycle.
  - Reset_n low during WAIT of a write to 0x030: MOC=0 immediately, and a later read of 0x030 returns the previously written value.
- Wrap, ADDR_WIDTH=9: write byte 0xA5 to 0x200; byte read of 0x000 returns 0x000000A5.
